// File: rtl/hamming_scrubber.sv
// Background scrubber for a Hamming(7,4)-protected counter: snapshots word and parity,
// checks one nibble per cycle, repairs single-bit errors and writes the result back.
module hamming_scrubber #(
  parameter int WIDTH       = 32,
  parameter int BLOCKS      = WIDTH / 4,
  parameter int PARITY_BITS = BLOCKS * 3,
  parameter int CNT_W       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           counter_i,
  input  logic [PARITY_BITS-1:0]     parity_stored_i,
  output logic                       wr_req_o,
  input  logic                       wr_ack_i,
  output logic [WIDTH-1:0]           wr_data_o,
  output logic [PARITY_BITS-1:0]     wr_parity_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       abort_o,
  output logic                       err_valid_o,
  output logic [$clog2(BLOCKS)-1:0]  err_block_o,
  output logic [2:0]                 err_syn_o,
  output logic [CNT_W-1:0]           corr_data_cnt_o,
  output logic [CNT_W-1:0]           corr_par_cnt_o
);

  localparam int IDX_W = $clog2(BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [PARITY_BITS-1:0] par_q, par_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   any_err_q, any_err_d;
  logic                   err_valid_q, err_valid_d;
  logic [IDX_W-1:0]       err_block_q, err_block_d;
  logic [2:0]             err_syn_q, err_syn_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [CNT_W-1:0]       data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]       par_cnt_q, par_cnt_d;

  // Every block is decoded in parallel; the scan index picks which one commits this cycle.
  logic [PARITY_BITS-1:0] syn_all_w;
  logic [WIDTH-1:0]       fix_data_w;
  logic [PARITY_BITS-1:0] fix_par_w;
  logic [BLOCKS-1:0]      data_hit_w;
  logic [BLOCKS-1:0]      par_hit_w;

  for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_blk
    logic [3:0] d;
    logic [2:0] stored;
    logic [2:0] calc;
    logic [2:0] syn;
    logic [3:0] flip_d;
    logic [2:0] flip_p;

    assign d      = data_q[4*gi +: 4];
    assign stored = par_q[3*gi +: 3];
    assign calc   = {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    assign syn    = calc ^ stored;
    assign flip_d = {syn == 3'b110, syn == 3'b101, syn == 3'b011, syn == 3'b111};
    assign flip_p = {syn == 3'b100, syn == 3'b010, syn == 3'b001};

    assign syn_all_w[3*gi +: 3]  = syn;
    assign fix_data_w[4*gi +: 4] = d ^ flip_d;
    assign fix_par_w[3*gi +: 3]  = stored ^ flip_p;
    assign data_hit_w[gi]        = |flip_d;
    assign par_hit_w[gi]         = |flip_p;
  end

  logic [2:0] cur_syn;
  logic       cur_data_hit;
  logic       cur_par_hit;

  assign cur_syn      = syn_all_w[idx_q*3 +: 3];
  assign cur_data_hit = data_hit_w[idx_q];
  assign cur_par_hit  = par_hit_w[idx_q];

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_d       = par_q;
    idx_d       = idx_q;
    any_err_d   = any_err_q;
    err_valid_d = 1'b0;
    err_block_d = err_block_q;
    err_syn_d   = err_syn_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    data_cnt_d  = data_cnt_q;
    par_cnt_d   = par_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i && !enable_i) begin
          data_d    = counter_i;
          par_d     = parity_stored_i;
          idx_d     = '0;
          any_err_d = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // An abort wins over the block that would have been scanned this cycle.
        if (enable_i) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          data_d[idx_q*4 +: 4] = fix_data_w[idx_q*4 +: 4];
          par_d[idx_q*3 +: 3]  = fix_par_w[idx_q*3 +: 3];
          if (cur_syn != 3'b000) begin
            err_valid_d = 1'b1;
            err_block_d = idx_q;
            err_syn_d   = cur_syn;
            any_err_d   = 1'b1;
          end
          if (cur_data_hit && data_cnt_q != CNT_MAX) begin
            data_cnt_d = data_cnt_q + CNT_W'(1);
          end
          if (cur_par_hit && par_cnt_q != CNT_MAX) begin
            par_cnt_d = par_cnt_q + CNT_W'(1);
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = (any_err_q || cur_syn != 3'b000) ? WRITE : DONE;
          end
        end
      end
      WRITE: begin
        if (enable_i) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (wr_ack_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      par_q       <= '0;
      idx_q       <= '0;
      any_err_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_block_q <= '0;
      err_syn_q   <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      data_cnt_q  <= '0;
      par_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      any_err_q   <= any_err_d;
      err_valid_q <= err_valid_d;
      err_block_q <= err_block_d;
      err_syn_q   <= err_syn_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      data_cnt_q  <= data_cnt_d;
      par_cnt_q   <= par_cnt_d;
    end
  end

  // The snapshot registers double as the write-back holding registers.
  assign wr_req_o        = (state_q == WRITE);
  assign wr_data_o       = data_q;
  assign wr_parity_o     = par_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign abort_o         = abort_q;
  assign err_valid_o     = err_valid_q;
  assign err_block_o     = err_block_q;
  assign err_syn_o       = err_syn_q;
  assign corr_data_cnt_o = data_cnt_q;
  assign corr_par_cnt_o  = par_cnt_q;

endmodule
